// File: rtl/fmc_d_ctrl.sv
// FMC D-port slave sequencer: address latch, write-beat assembly, read turnaround, tristate ownership.
// Latency: first data beat DATA_LATENCY clocks after the address-latch edge; sys_wr_en one clock after the hi beat.
// Backpressure: none by default (late read data drives zeros and sets err_latency); FMC_D_CTRL_NWAIT_EN stalls the host via fmc_nwait.
module fmc_d_ctrl #(
  parameter int BUS_WIDTH    = 16,
  parameter int DATA_LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fmc_ne,
  input  logic                   fmc_nl,
  input  logic                   fmc_nwe,
  input  logic [BUS_WIDTH-1:0]   buf_ro,
  output logic [BUS_WIDTH-1:0]   buf_di,
  output logic                   buf_t,
  output logic [BUS_WIDTH-1:0]   sys_addr,
  output logic                   sys_wr_en,
  output logic [2*BUS_WIDTH-1:0] sys_wr_data,
  output logic                   sys_rd_en,
  input  logic [2*BUS_WIDTH-1:0] sys_rd_data,
  input  logic                   sys_rd_ack,
  output logic                   err_latency,
  input  logic                   err_clr
`ifdef FMC_D_CTRL_NWAIT_EN
  ,
  output logic                   fmc_nwait
`endif
);

  localparam int DW = 2 * BUS_WIDTH;
  localparam logic [3:0] LAT_LOAD = 4'(DATA_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LAT, ST_WR_LO, ST_WR_HI, ST_RD_LO, ST_RD_HI, ST_WAIT
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           dir_q, dir_d;          // 1 = read
  logic           got_q, got_d;          // first ack of this read already captured
  logic [DW-1:0]  rd_buf_q, rd_buf_d;
  logic [BUS_WIDTH-1:0] wr_lo_q, wr_lo_d;
  logic           buf_t_q, buf_t_d;
  logic [BUS_WIDTH-1:0] buf_di_q, buf_di_d;
  logic [BUS_WIDTH-1:0] sys_addr_q, sys_addr_d;
  logic           sys_wr_en_q, sys_wr_en_d;
  logic [DW-1:0]  sys_wr_data_q, sys_wr_data_d;
  logic           sys_rd_en_q, sys_rd_en_d;
  logic           err_q, err_d;
  logic           err_set;
  logic [DW-1:0]  rd_now;
`ifdef FMC_D_CTRL_NWAIT_EN
  logic           nwait_q, nwait_d;
`endif

  // Next-state and registered-output logic; abort on fmc_ne overrides everything below the case.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    got_d         = got_q;
    rd_buf_d      = rd_buf_q;
    wr_lo_d       = wr_lo_q;
    buf_t_d       = buf_t_q;
    buf_di_d      = buf_di_q;
    sys_addr_d    = sys_addr_q;
    sys_wr_en_d   = 1'b0;
    sys_wr_data_d = sys_wr_data_q;
    sys_rd_en_d   = 1'b0;
    err_set       = 1'b0;
`ifdef FMC_D_CTRL_NWAIT_EN
    nwait_d       = nwait_q;
`endif
    // Data for the turnaround edge: first captured ack wins, an ack on this very edge is bypassed in.
    rd_now = got_q ? rd_buf_q : (sys_rd_ack ? sys_rd_data : '0);

    case (state_q)
      ST_IDLE: begin
        buf_t_d  = 1'b1;
        buf_di_d = '0;
        if (!fmc_ne && !fmc_nl) begin
          sys_addr_d  = buf_ro;
          dir_d       = fmc_nwe;
          cnt_d       = LAT_LOAD;
          got_d       = 1'b0;
          rd_buf_d    = '0;
          sys_rd_en_d = fmc_nwe;
          state_d     = ST_LAT;
        end
      end
      ST_LAT: begin
        if (dir_q && sys_rd_ack && !got_q) begin
          rd_buf_d = sys_rd_data;
          got_d    = 1'b1;
        end
        if (cnt_q == 4'd0) begin
          if (dir_q) begin
`ifdef FMC_D_CTRL_NWAIT_EN
            if (!got_q && !sys_rd_ack) begin
              nwait_d = 1'b0;
              state_d = ST_WAIT;
            end else begin
              rd_buf_d = rd_now;
              buf_t_d  = 1'b0;
              buf_di_d = rd_now[BUS_WIDTH-1:0];
              state_d  = ST_RD_LO;
            end
`else
            err_set  = !got_q && !sys_rd_ack;
            rd_buf_d = rd_now;
            buf_t_d  = 1'b0;
            buf_di_d = rd_now[BUS_WIDTH-1:0];
            state_d  = ST_RD_LO;
`endif
          end else begin
            state_d = ST_WR_LO;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WR_LO: begin
        wr_lo_d = buf_ro;
        state_d = ST_WR_HI;
      end
      ST_WR_HI: begin
        sys_wr_en_d   = 1'b1;
        sys_wr_data_d = {buf_ro, wr_lo_q};
        state_d       = ST_IDLE;
      end
      ST_RD_LO: begin
        buf_di_d = rd_buf_q[DW-1:BUS_WIDTH];
        state_d  = ST_RD_HI;
      end
      ST_RD_HI: begin
        buf_t_d  = 1'b1;
        buf_di_d = '0;
        state_d  = ST_IDLE;
      end
`ifdef FMC_D_CTRL_NWAIT_EN
      ST_WAIT: begin
        if (sys_rd_ack) begin
          rd_buf_d = sys_rd_data;
          buf_t_d  = 1'b0;
          buf_di_d = sys_rd_data[BUS_WIDTH-1:0];
          nwait_d  = 1'b1;
          state_d  = ST_RD_LO;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && fmc_ne) begin
      state_d     = ST_IDLE;
      buf_t_d     = 1'b1;
      buf_di_d    = '0;
      sys_wr_en_d = 1'b0;
      err_set     = 1'b0;
`ifdef FMC_D_CTRL_NWAIT_EN
      nwait_d     = 1'b1;
`endif
    end

    // Set has priority over a coincident clear.
    err_d = err_set | (err_q & ~err_clr);
  end

  // State and output registers; reset releases the pins immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      got_q         <= 1'b0;
      rd_buf_q      <= '0;
      wr_lo_q       <= '0;
      buf_t_q       <= 1'b1;
      buf_di_q      <= '0;
      sys_addr_q    <= '0;
      sys_wr_en_q   <= 1'b0;
      sys_wr_data_q <= '0;
      sys_rd_en_q   <= 1'b0;
      err_q         <= 1'b0;
`ifdef FMC_D_CTRL_NWAIT_EN
      nwait_q       <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      got_q         <= got_d;
      rd_buf_q      <= rd_buf_d;
      wr_lo_q       <= wr_lo_d;
      buf_t_q       <= buf_t_d;
      buf_di_q      <= buf_di_d;
      sys_addr_q    <= sys_addr_d;
      sys_wr_en_q   <= sys_wr_en_d;
      sys_wr_data_q <= sys_wr_data_d;
      sys_rd_en_q   <= sys_rd_en_d;
      err_q         <= err_d;
`ifdef FMC_D_CTRL_NWAIT_EN
      nwait_q       <= nwait_d;
`endif
    end
  end

  assign buf_t       = buf_t_q;
  assign buf_di      = buf_di_q;
  assign sys_addr    = sys_addr_q;
  assign sys_wr_en   = sys_wr_en_q;
  assign sys_wr_data = sys_wr_data_q;
  assign sys_rd_en   = sys_rd_en_q;
  assign err_latency = err_q;
`ifdef FMC_D_CTRL_NWAIT_EN
  assign fmc_nwait   = nwait_q;
`endif

endmodule

// File: tb/tb_fmc_d_ctrl.sv
// Directed bench for fmc_d_ctrl with DATA_LATENCY=3.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Expected values are hand-derived from the FMC D-port timing.
module tb_fmc_d_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fmc_ne, fmc_nl, fmc_nwe;
  logic [15:0] buf_ro;
  logic [15:0] buf_di;
  logic        buf_t;
  logic [15:0] sys_addr;
  logic        sys_wr_en;
  logic [31:0] sys_wr_data;
  logic        sys_rd_en;
  logic [31:0] sys_rd_data;
  logic        sys_rd_ack;
  logic        err_latency;
  logic        err_clr;
`ifdef FMC_D_CTRL_NWAIT_EN
  logic        fmc_nwait;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fmc_d_ctrl #(.BUS_WIDTH(16), .DATA_LATENCY(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .fmc_ne(fmc_ne), .fmc_nl(fmc_nl), .fmc_nwe(fmc_nwe),
    .buf_ro(buf_ro), .buf_di(buf_di), .buf_t(buf_t),
    .sys_addr(sys_addr), .sys_wr_en(sys_wr_en), .sys_wr_data(sys_wr_data),
    .sys_rd_en(sys_rd_en), .sys_rd_data(sys_rd_data), .sys_rd_ack(sys_rd_ack),
    .err_latency(err_latency), .err_clr(err_clr)
`ifdef FMC_D_CTRL_NWAIT_EN
    , .fmc_nwait(fmc_nwait)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an address beat; returns just after the latching edge with strobes released.
  task automatic addr_beat(input logic nwe, input logic [15:0] a);
    fmc_ne  = 1'b0;
    fmc_nl  = 1'b0;
    fmc_nwe = nwe;
    buf_ro  = a;
    step();
    fmc_nl  = 1'b1;
    buf_ro  = 16'h0;
  endtask

  initial begin
    reset_n = 1'b0; fmc_ne = 1'b1; fmc_nl = 1'b1; fmc_nwe = 1'b1;
    buf_ro = '0; sys_rd_data = '0; sys_rd_ack = 1'b0; err_clr = 1'b0;
    step(); step();
    chk("rst_buf_t", 32'(buf_t), 32'd1);
    chk("rst_buf_di", 32'(buf_di), 32'h0);
    chk("rst_addr", 32'(sys_addr), 32'h0);
    chk("rst_wr_en", 32'(sys_wr_en), 32'd0);
    chk("rst_wr_data", sys_wr_data, 32'h0);
    chk("rst_rd_en", 32'(sys_rd_en), 32'd0);
    chk("rst_err", 32'(err_latency), 32'd0);
    reset_n = 1'b1;
    step();

    // Write 0xDEADBEEF to 0x0040
    addr_beat(1'b0, 16'h0040);
    chk("wr_no_rd_en", 32'(sys_rd_en), 32'd0);
    step(); step();
    chk("wr_lat_buf_t", 32'(buf_t), 32'd1);
    step();                       // now in WR_LO
    buf_ro = 16'hBEEF; step();
    buf_ro = 16'hDEAD; step();
    chk("wr_en", 32'(sys_wr_en), 32'd1);
    chk("wr_addr", 32'(sys_addr), 32'h0040);
    chk("wr_data", sys_wr_data, 32'hDEADBEEF);
    chk("wr_buf_t", 32'(buf_t), 32'd1);
    fmc_ne = 1'b1; buf_ro = 16'h0;
    step();
    chk("wr_en_pulse", 32'(sys_wr_en), 32'd0);

    // Read 0x12345678 from 0x0008, ack one clock after sys_rd_en
    addr_beat(1'b1, 16'h0008);
    chk("rd_en", 32'(sys_rd_en), 32'd1);
    chk("rd_addr", 32'(sys_addr), 32'h0008);
    sys_rd_ack = 1'b1; sys_rd_data = 32'h12345678;
    step();
    sys_rd_ack = 1'b0; sys_rd_data = 32'hFFFFFFFF;
    chk("rd_en_pulse", 32'(sys_rd_en), 32'd0);
    step();
    chk("rd_lat_buf_t", 32'(buf_t), 32'd1);
    step();
    chk("rd_lo_buf_t", 32'(buf_t), 32'd0);
    chk("rd_lo_di", 32'(buf_di), 32'h5678);
    step();
    chk("rd_hi_buf_t", 32'(buf_t), 32'd0);
    chk("rd_hi_di", 32'(buf_di), 32'h1234);
    fmc_ne = 1'b1;
    step();
    chk("rd_end_buf_t", 32'(buf_t), 32'd1);
    chk("rd_end_di", 32'(buf_di), 32'h0);
    chk("rd_err", 32'(err_latency), 32'd0);

`ifndef FMC_D_CTRL_NWAIT_EN
    // Read with no ack: zeros on both beats, sticky error
    addr_beat(1'b1, 16'h0010);
    step(); step(); step();
    chk("miss_lo_buf_t", 32'(buf_t), 32'd0);
    chk("miss_lo_di", 32'(buf_di), 32'h0);
    chk("miss_err", 32'(err_latency), 32'd1);
    step();
    chk("miss_hi_di", 32'(buf_di), 32'h0);
    fmc_ne = 1'b1;
    step();
    chk("miss_end_buf_t", 32'(buf_t), 32'd1);
    chk("miss_err_sticky", 32'(err_latency), 32'd1);
    err_clr = 1'b1; sys_rd_ack = 1'b1; sys_rd_data = 32'hCAFEF00D;
    step();
    err_clr = 1'b0; sys_rd_ack = 1'b0;
    chk("miss_err_clr", 32'(err_latency), 32'd0);

    // Clear held across the miss edge: set wins
    addr_beat(1'b1, 16'h0012);
    err_clr = 1'b1;
    step(); step(); step();
    chk("miss_set_over_clr", 32'(err_latency), 32'd1);
    step();
    chk("miss_clr_after", 32'(err_latency), 32'd0);
    err_clr = 1'b0; fmc_ne = 1'b1;
    step();
`else
    // Read with ack 5 clocks late: host stalled via fmc_nwait
    addr_beat(1'b1, 16'h0060);
    chk("nw_idle_lat", 32'(fmc_nwait), 32'd1);
    step(); step(); step();
    chk("nw_wait0", 32'(fmc_nwait), 32'd0);
    chk("nw_wait_buf_t", 32'(buf_t), 32'd1);
    step();
    chk("nw_wait1", 32'(fmc_nwait), 32'd0);
    sys_rd_ack = 1'b1; sys_rd_data = 32'h9ABCDEF0;
    chk("nw_wait2", 32'(fmc_nwait), 32'd0);
    step();
    sys_rd_ack = 1'b0;
    chk("nw_released", 32'(fmc_nwait), 32'd1);
    chk("nw_lo_buf_t", 32'(buf_t), 32'd0);
    chk("nw_lo_di", 32'(buf_di), 32'hDEF0);
    step();
    chk("nw_hi_di", 32'(buf_di), 32'h9ABC);
    fmc_ne = 1'b1;
    step();
    chk("nw_end_buf_t", 32'(buf_t), 32'd1);
    chk("nw_err", 32'(err_latency), 32'd0);
`endif

    // Write aborted in WR_LO, then an immediate write
    addr_beat(1'b0, 16'h0020);
    step(); step(); step();       // WR_LO
    fmc_ne = 1'b1; buf_ro = 16'h7777;
    step();
    chk("abort_wr_en", 32'(sys_wr_en), 32'd0);
    chk("abort_buf_t", 32'(buf_t), 32'd1);
    addr_beat(1'b0, 16'h0030);
    chk("abort_no_wr_en", 32'(sys_wr_en), 32'd0);
    step(); step(); step();
    buf_ro = 16'h1111; step();
    buf_ro = 16'h2222; step();
    chk("re_wr_en", 32'(sys_wr_en), 32'd1);
    chk("re_wr_addr", 32'(sys_addr), 32'h0030);
    chk("re_wr_data", sys_wr_data, 32'h22221111);
    fmc_ne = 1'b1;
    step();

    // Async reset while driving the lo read beat
    addr_beat(1'b1, 16'h0044);
    sys_rd_ack = 1'b1; sys_rd_data = 32'hAAAA5555;
    step();
    sys_rd_ack = 1'b0;
    step(); step();
    chk("ar_lo_buf_t", 32'(buf_t), 32'd0);
    chk("ar_lo_di", 32'(buf_di), 32'h5555);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_buf_t", 32'(buf_t), 32'd1);
    chk("ar_buf_di", 32'(buf_di), 32'h0);
    chk("ar_strobes", {30'd0, sys_rd_en, sys_wr_en}, 32'd0);
    fmc_ne = 1'b1;
    #1 reset_n = 1'b1;
    step();
    addr_beat(1'b1, 16'h0050);
    chk("ar_new_addr", 32'(sys_addr), 32'h0050);
    chk("ar_new_rd_en", 32'(sys_rd_en), 32'd1);
    fmc_ne = 1'b1;
    step();
    chk("ar_abort_buf_t", 32'(buf_t), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fmc_d_ctrl.md
Name: fmc_d_ctrl

Overview:
- Synchronous FMC slave sequencer for the bidirectional, multiplexed 16-bit FMC D port.
- Sits between the FMC pin buffers (buf_di/buf_ro/buf_t) and the core-side register bus.
- Per transaction it latches the address beat, waits a fixed data latency, then either assembles two write beats into one 32-bit write or turns the bus around and drives two read beats.
- Owns all tristate sequencing; no other block drives buf_t.

Parameters:
- BUS_WIDTH, 16, FMC D bus width; address width; sys data width is 2*BUS_WIDTH.
- DATA_LATENCY, 3, clocks from the address-latch edge to the first data beat; legal range 2..15.

Ports:
- clk  in  1  FMC clock; all FMC strobes are synchronous to it.
- reset_n  in  1  asynchronous active-low reset.
- fmc_ne  in  1  chip enable, active low.
- fmc_nl  in  1  address valid, active low.
- fmc_nwe  in  1  0=write, 1=read; sampled with the address beat.
- buf_ro  in  BUS_WIDTH  receiver value from the pins.
- buf_di  out  BUS_WIDTH  value driven onto the pins.
- buf_t  out  1  1=pins tristated, 0=driving.
- sys_addr  out  BUS_WIDTH  latched transaction address.
- sys_wr_en  out  1  one-clock write strobe.
- sys_wr_data  out  2*BUS_WIDTH  {hi beat, lo beat}.
- sys_rd_en  out  1  one-clock read request.
- sys_rd_data  in  2*BUS_WIDTH  read data; valid when sys_rd_ack=1.
- sys_rd_ack  in  1  read data valid; one clock or more after sys_rd_en.
- err_latency  out  1  sticky; read data missed its deadline.
- err_clr  in  1  clears err_latency.

Behaviour:
- Reset values: buf_t=1, buf_di=0, sys_addr=0, sys_wr_en=0, sys_wr_data=0, sys_rd_en=0, err_latency=0; state IDLE. All outputs are registered.
- IDLE:
  - Condition fmc_ne=0 & fmc_nl=0 → latch sys_addr=buf_ro and dir=fmc_nwe.
  - Load the latency counter with DATA_LATENCY-1.
  - Go to LAT.
- LAT:
  - Counter decrements each clock.
  - Read: sys_rd_en pulses on the first LAT clock only.
  - At count 0: write goes to WR_LO, read goes to RD_LO.
- Read data capture: sys_rd_ack while waiting latches sys_rd_data into an internal rd_buf. Later acks are ignored.
- Turnaround:
  - On the LAT→RD_LO transition, buf_t=0 and buf_di=rd_buf[BUS_WIDTH-1:0], both registered.
  - The pins are therefore driven from the first read beat clock.
- RD_LO → RD_HI: buf_di=rd_buf upper half.
- RD_HI → IDLE: buf_t=1, buf_di=0.
- WR_LO: capture buf_ro as the lo beat → WR_HI.
- WR_HI:
  - Capture buf_ro as the hi beat.
  - Next clock: sys_wr_en=1 for one clock with sys_addr and sys_wr_data={hi,lo}.
  - Go to IDLE.
- Back-to-back: a new address beat is accepted in IDLE on the clock after RD_HI/WR_HI.
- Abort:
  - fmc_ne=1 in any non-IDLE state → IDLE next clock, buf_t=1 next clock.
  - A write aborted before WR_HI produces no sys_wr_en.
  - A read aborted after sys_rd_en keeps its request; a late ack is discarded.
- Latency miss (read, macro off): no ack by the end of LAT → drive 0 on both beats and set err_latency=1.
- err_latency:
  - err_clr=1 clears it.
  - A simultaneous set and clear leaves it set.
- fmc_nl=0 outside IDLE is ignored.
- Async reset mid-transaction: buf_t=1 immediately, no strobes.

Optional Feature:
- Macro: FMC_D_CTRL_NWAIT_EN.
- Defined:
  - Adds output port fmc_nwait (1 bit, active low, reset 1).
  - In read, if LAT reaches 0 without an ack, stay in a WAIT state with fmc_nwait=0 and buf_t=1.
  - On ack, latch the data, set fmc_nwait=1, and go to RD_LO next clock.
  - err_latency is never set by a read.
  - fmc_ne=1 in WAIT → IDLE with fmc_nwait=1.
- Not defined: no fmc_nwait port; latency-miss behaviour is as in Behaviour.

Test Plan:
- Write, DATA_LATENCY=3: addr beat 0x0040 with nwe=0, then beats 0xBEEF, 0xDEAD → sys_wr_en one clock with sys_addr=0x0040 and sys_wr_data=0xDEADBEEF; buf_t stays 1 throughout.
- Read, ack 1 clock after sys_rd_en with 0x12345678, addr 0x0008, nwe=1 → sys_rd_en one pulse; buf_t=0 for exactly 2 clocks; pins carry 0x5678 then 0x1234; then buf_t=1.
- Read with no ack (macro off) → pins 0x0000, 0x0000; err_latency=1 until err_clr pulse; simultaneous ack and err_clr leaves it 0 after the clear.
- Write aborted with fmc_ne=1 during WR_LO → no sys_wr_en, state IDLE; an immediate new write completes normally.
- Async reset_n low during RD_LO → buf_t=1 in the same clock, all strobes 0; after release, IDLE accepts a new address.
- Macro on, ack 5 clocks late → fmc_nwait low from the end of LAT until the ack clock; correct two read beats follow; err_latency stays 0.
